// File: rtl/shared_key_perm_sched.sv
// shared_key_perm_sched
//   Iterative key-schedule nibble-permutation engine for the masked uBlock
//   datapath. A NUM_SHARES-way Boolean-shared 64-bit key half is loaded once,
//   then ROUNDS shared round-key words are streamed out. Between words every
//   share is independently passed through the uBlock key permutation PK
//   (or PK^-1). The permutation is linear and share-local, so shares never mix.
//
//   Optional build macro: SHARE_REFRESH_EN
//     When defined, adds rand_in and re-randomises the sharing on every
//     permute step (unshared value unchanged). When undefined, pure permutation.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   load handshake; in_ready is high only in IDLE
//   in_dir              0 = forward PK, 1 = inverse PK (sampled on load)
//   in_shares           share s at bits [64s+63:64s]
//   out_valid/out_ready round-key word handshake
//   out_shares          current shared round key (registered)
//   round_idx           index of the word on out_shares (registered)
//   done                one-cycle pulse after the last word is accepted
//   rand_in             (SHARE_REFRESH_EN only) 64*(NUM_SHARES-1) fresh random bits
module shared_key_perm_sched #(
    parameter int NUM_SHARES = 2,
    parameter int ROUNDS     = 16,
    parameter int RW         = $clog2(ROUNDS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_dir,
    input  logic [64*NUM_SHARES-1:0] in_shares,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [64*NUM_SHARES-1:0] out_shares,
    output logic [RW-1:0]           round_idx,
    output logic                    done
`ifdef SHARE_REFRESH_EN
    ,
    input  logic [64*(NUM_SHARES-1)-1:0] rand_in
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [RW-1:0] LAST_IDX = RW'(ROUNDS - 1);

    state_e                    state_q, state_d;
    logic [64*NUM_SHARES-1:0]  shares_q, shares_d;
    logic [RW-1:0]             cnt_q, cnt_d;
    logic                      dir_q, dir_d;
    logic                      done_q, done_d;
    logic [64*NUM_SHARES-1:0]  stepped;

    // Forward PK: out nibble 15..0 <- in nibble 9,15,7,2,14,0,10,5,11,6,3,13,4,12,8,1
    function automatic logic [63:0] pk_fwd(input logic [63:0] x);
        return {x[39:36], x[63:60], x[31:28], x[11:8],
                x[59:56], x[3:0],   x[43:40], x[23:20],
                x[47:44], x[27:24], x[15:12], x[55:52],
                x[19:16], x[51:48], x[35:32], x[7:4]};
    endfunction

    // Inverse PK: out nibble 15..0 <- in nibble 14,11,4,2,7,9,15,1,13,6,8,3,5,12,0,10
    function automatic logic [63:0] pk_inv(input logic [63:0] x);
        return {x[59:56], x[47:44], x[19:16], x[11:8],
                x[31:28], x[39:36], x[63:60], x[7:4],
                x[55:52], x[27:24], x[35:32], x[15:12],
                x[23:20], x[51:48], x[3:0],   x[43:40]};
    endfunction

    // Next share value on an accepted non-final word.
    always_comb begin
`ifdef SHARE_REFRESH_EN
        logic [63:0] r_acc;
        r_acc = '0;
`endif
        stepped = '0;
        for (int unsigned s = 0; s < NUM_SHARES; s++) begin
            stepped[64*s +: 64] = dir_q ? pk_inv(shares_q[64*s +: 64])
                                        : pk_fwd(shares_q[64*s +: 64]);
        end
`ifdef SHARE_REFRESH_EN
        // Each r_s enters twice (share s and the last share), so the XOR of
        // all shares is untouched while the individual shares are refreshed.
        for (int unsigned s = 0; s < NUM_SHARES - 1; s++) begin
            stepped[64*s +: 64] = stepped[64*s +: 64] ^ rand_in[64*s +: 64];
            r_acc               = r_acc ^ rand_in[64*s +: 64];
        end
        stepped[64*(NUM_SHARES-1) +: 64] = stepped[64*(NUM_SHARES-1) +: 64] ^ r_acc;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shares_q <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shares_q <= shares_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        shares_d = shares_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shares_d = in_shares;
                    dir_d    = in_dir;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        // Final word accepted: shares hold, pulse done.
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        shares_d = stepped;
                        cnt_d    = cnt_q + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: all driven from registers
    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == RUN);
        out_shares = shares_q;
        round_idx  = cnt_q;
        done       = done_q;
    end

endmodule

// File: doc/shared_key_perm_sched.md
Name: shared_key_perm_sched

Overview:
Iterative, share-parametrised key-schedule nibble-permutation engine for the masked uBlock datapath.
- Loads one NUM_SHARES-way Boolean-shared 64-bit key half.
- Emits ROUNDS successive shared round-key words, applying the fixed uBlock 16-nibble key permutation PK (or its inverse) to every share independently between words.
- Sits between the key-load interface and the shared round-key XOR stage.
- The permutation is linear and applied share-locally, so non-completeness is preserved.

Parameters:
- NUM_SHARES, 2, number of Boolean shares (legal 2..4).
- ROUNDS, 16, round-key words emitted per load (legal 2..64).
- RW, $clog2(ROUNDS), width of round_idx.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  load request.
- in_ready  out  1  high only in IDLE.
- in_dir  in  1  0 = forward PK, 1 = inverse PK; sampled on load.
- in_shares  in  64*NUM_SHARES  share s at bits [64s+63:64s].
- out_valid  out  1  round-key word valid.
- out_ready  in  1  consumer accept.
- out_shares  out  64*NUM_SHARES  current shared round key.
- round_idx  out  RW  index of the word on out_shares.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State = IDLE.
  - Share registers, round counter, dir register and done are all cleared to 0.
  - out_valid = 0 and in_ready = 1 immediately after release.
- Nibble n means bits [4n+3:4n].
- Forward PK, listed as out nibble 15..0 <- in nibble: 9, 15, 7, 2, 14, 0, 10, 5, 11, 6, 3, 13, 4, 12, 8, 1.
- Inverse PK, listed as out 15..0 <- in: 14, 11, 4, 2, 7, 9, 15, 1, 13, 6, 8, 3, 5, 12, 0, 10.
- FSM IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid: latch in_shares and in_dir, clear the counter, go to RUN next cycle.
- FSM RUN:
  - in_ready = 0, out_valid = 1.
  - out_shares = registered shares; round_idx = counter. Both are driven directly from registers, with no combinational input-to-output path.
  - On out_valid & out_ready with counter < ROUNDS-1: each share <= PK(share) (or PK^-1 if dir = 1); counter increments.
  - On acceptance with counter == ROUNDS-1: go to IDLE, done = 1 for the next cycle, share registers hold.
  - out_ready low: all registers hold. Output stays stable until accepted (AXI-stream rule).
- Latency:
  - Load to first out_valid: 1 cycle.
  - With out_ready held high: one word per cycle. Word k = PK^k(loaded value).
  - ROUNDS words complete in ROUNDS+1 cycles from load.
- in_valid during RUN is ignored (no load, no state change). in_dir and in_shares are don't-care outside the load cycle.
- done pulse coincides with in_ready returning to 1. A load in that same cycle is accepted.
- Reset mid-RUN aborts immediately: no done, outputs cleared.
- Forward then inverse over k steps must return the loaded value exactly.

Optional Feature:
SHARE_REFRESH_EN
- Defined:
  - Adds input rand_in, width 64*(NUM_SHARES-1).
  - On every permute step, share s (s < NUM_SHARES-1) ^= r_s, and the last share ^= XOR of all r_s. The unshared value is unchanged.
  - rand_in is sampled only on acceptance cycles. No refresh is applied at load.
- Undefined: port absent, pure permutation.
- The unshared (XOR-of-shares) output must be identical in both builds.

Test Plan:
1. Forward step:
   - Stimulus: NUM_SHARES = 2, ROUNDS = 16, dir = 0, share0 = 0xFEDCBA9876543210, share1 = 0, out_ready = 1.
   - Required: word0 share0 = 0xFEDCBA9876543210, word1 share0 = 0x9F72E0A5B63D4C81, share1 = 0 throughout, round_idx 0..15, done one cycle after word 15.
2. Inverse step:
   - Stimulus: dir = 1, share0 = 0x9F72E0A5B63D4C81, share1 = 0x0123456789ABCDEF.
   - Required: word1 share0 = 0xFEDCBA9876543210, word1 share1 = PK^-1(0x0123456789ABCDEF), XOR of the shares equals PK^-1 of the unshared input.
3. Backpressure:
   - Stimulus: toggle out_ready 1,0,0,1 pseudo-randomly.
   - Required: out_shares and round_idx stable while stalled, exactly 16 words, no duplicates or skips.
4. Busy load:
   - Stimulus: in_valid held high during RUN with different data.
   - Required: ignored, in_ready = 0. Back-to-back load on the done cycle accepted, round_idx restarts at 0.
5. Reset mid-run:
   - Stimulus: assert rst_n low at round_idx = 7.
   - Required: out_valid = 0 and out_shares = 0 asynchronously, no done pulse, in_ready = 1 after release.
6. Refresh build:
   - Stimulus: SHARE_REFRESH_EN defined, NUM_SHARES = 3, random rand_in.
   - Required: per-word XOR of the shares matches the reference PK^k sequence, and individual shares differ from the non-refresh build.
